// File: rtl/rv_mul_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_mul_seq_if : control/datapath bundle of the byte-serial multiply sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
interface rv_mul_seq_if;
    logic       start;
    logic [3:0] a_bz;
    logic [3:0] b_bz;
    logic       busy;
    logic       done;
    logic [1:0] Ma_sel;
    logic [1:0] Mb_sel;
    logic [4:0] Mshift_val;
    logic       Mupd_reg;
    logic       Mclr_reg;

    modport master (
        output start, a_bz, b_bz,
        input  busy, done, Ma_sel, Mb_sel, Mshift_val, Mupd_reg, Mclr_reg
    );

    modport slave (
        input  start, a_bz, b_bz,
        output busy, done, Ma_sel, Mb_sel, Mshift_val, Mupd_reg, Mclr_reg
    );
endinterface
`default_nettype wire

// File: rtl/rv_mul_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_mul_seq : sequencer issuing byte partial products (i+j<=3) for a 32-bit MUL
// Revision 1.0
// ---------------------------------------------------------------------------
module rv_mul_seq #(
    parameter int SKIP_ZERO = 1,
    parameter int BYTES     = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rv_mul_seq_if.slave  mul
);
    localparam int NSTEPS = BYTES * (BYTES + 1) / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLR  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Step s -> (i, j), ordered by i then j over the pairs with i+j <= 3
    function automatic logic [1:0] step_i(input int s);
        case (s)
            0, 1, 2, 3: step_i = 2'd0;
            4, 5, 6:    step_i = 2'd1;
            7, 8:       step_i = 2'd2;
            default:    step_i = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] step_j(input int s);
        case (s)
            0, 4, 7, 9: step_j = 2'd0;
            1, 5, 8:    step_j = 2'd1;
            2, 6:       step_j = 2'd2;
            default:    step_j = 2'd3;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_step;
    logic [3:0]        w_step_nxt;
    logic [NSTEPS-1:0] r_mask;
    logic [NSTEPS-1:0] w_mask_in;
    logic [NSTEPS-1:0] w_avail;
    logic              w_found;
    logic [3:0]        w_first;
    logic [1:0]        w_i;
    logic [1:0]        w_j;
    logic [1:0]        w_sum;

    for (genvar s = 0; s < NSTEPS; s++) begin : g_mask
        assign w_mask_in[s] = (SKIP_ZERO != 0) &&
                              (mul.a_bz[step_i(s)] || mul.b_bz[step_j(s)]);
    end

    // Lowest unmasked step: any step from CLR, only later steps from ACC
    always_comb begin
        w_avail = '0;
        w_found = 1'b0;
        w_first = '0;
        for (int k = 0; k < NSTEPS; k++) begin
            w_avail[k] = !r_mask[k] && ((r_state == S_CLR) || (k > int'(r_step)));
        end
        for (int k = NSTEPS - 1; k >= 0; k--) begin
            if (w_avail[k]) begin
                w_found = 1'b1;
                w_first = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (r_state == S_IDLE && mul.start) begin
                r_mask <= w_mask_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            S_IDLE: begin
                if (mul.start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR, S_ACC: begin
                if (w_found) begin
                    w_state_nxt = S_ACC;
                    w_step_nxt  = w_first;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_i   = step_i(int'(r_step));
    assign w_j   = step_j(int'(r_step));
    assign w_sum = w_i + w_j;

    always_comb begin
        mul.busy       = 1'b0;
        mul.done       = 1'b0;
        mul.Ma_sel     = '0;
        mul.Mb_sel     = '0;
        mul.Mshift_val = '0;
        mul.Mupd_reg   = 1'b0;
        mul.Mclr_reg   = 1'b0;
        case (r_state)
            S_CLR: begin
                mul.busy     = 1'b1;
                mul.Mclr_reg = 1'b1;
            end
            S_ACC: begin
                mul.busy       = 1'b1;
                mul.Ma_sel     = w_i;
                mul.Mb_sel     = w_j;
                mul.Mshift_val = {w_sum, 3'b000};
                mul.Mupd_reg   = 1'b1;
            end
            S_DONE: begin
                mul.busy = 1'b1;
                mul.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_rv_mul_seq.sv
`default_nettype none
// Directed bench: one skipping and one non-skipping sequencer share stimulus,
// a small product-register model accumulates what the sequencers issue.
module tb_rv_mul_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_bz = '0;
    logic [3:0] b_bz = '0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_mul_seq_if bus0 ();
    rv_mul_seq_if bus1 ();

    assign bus0.start = start;
    assign bus0.a_bz  = a_bz;
    assign bus0.b_bz  = b_bz;
    assign bus1.start = start;
    assign bus1.a_bz  = a_bz;
    assign bus1.b_bz  = b_bz;

    rv_mul_seq #(.SKIP_ZERO(1), .BYTES(4)) u_dut0 (.clk(clk), .rst(rst), .mul(bus0));
    rv_mul_seq #(.SKIP_ZERO(0), .BYTES(4)) u_dut1 (.clk(clk), .rst(rst), .mul(bus1));

    logic [1:0] busy_w, done_w, upd_w, clr_w;
    logic [1:0] ma_w [2];
    logic [1:0] mb_w [2];
    logic [4:0] sh_w [2];
    assign busy_w = {bus1.busy, bus0.busy};
    assign done_w = {bus1.done, bus0.done};
    assign upd_w  = {bus1.Mupd_reg, bus0.Mupd_reg};
    assign clr_w  = {bus1.Mclr_reg, bus0.Mclr_reg};
    assign ma_w[0] = bus0.Ma_sel;
    assign ma_w[1] = bus1.Ma_sel;
    assign mb_w[0] = bus0.Mb_sel;
    assign mb_w[1] = bus1.Mb_sel;
    assign sh_w[0] = bus0.Mshift_val;
    assign sh_w[1] = bus1.Mshift_val;

    int          cyc;
    int          quiet_from;
    logic [31:0] clr_mask [2];
    logic [31:0] done_mask [2];
    int          done_cnt [2];
    int          busy_cnt [2];
    int          upd_cnt [2];
    logic [63:0] shift_seq [2];
    logic [63:0] sel_seq [2];
    logic [31:0] prod [2];
    int          excl_bad;
    int          shift_bad;
    int          quiet_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        cyc = 0;
        quiet_from = 999;
        for (int d = 0; d < 2; d++) begin
            clr_mask[d]  = '0;
            done_mask[d] = '0;
            done_cnt[d]  = 0;
            busy_cnt[d]  = 0;
            upd_cnt[d]   = 0;
            shift_seq[d] = '0;
            sel_seq[d]   = '0;
            prod[d]      = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Drive a start request; returns just after the edge that samples it
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clk);
        cur_a = a;
        cur_b = b;
        for (int k = 0; k < 4; k++) begin
            a_bz[k] = (a[8*k +: 8] == 8'h00);
            b_bz[k] = (b[8*k +: 8] == 8'h00);
        end
        start = 1'b1;
        @(posedge clk);
        clear_logs();
        #1;
        if (!hold) begin
            start = 1'b0;
            a_bz  = ~a_bz;
            b_bz  = ~b_bz;
        end
    endtask

    task automatic collect(input int n);
        logic [7:0] ab, bb;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (clr_w[d] && upd_w[d]) excl_bad++;
                if (sh_w[d][2:0] != 3'b000) shift_bad++;
                if (cyc >= quiet_from &&
                    (busy_w[d] || done_w[d] || upd_w[d] || clr_w[d] ||
                     ma_w[d] != 2'd0 || mb_w[d] != 2'd0 || sh_w[d] != 5'd0))
                    quiet_bad++;
                if (busy_w[d]) busy_cnt[d]++;
                if (clr_w[d]) begin
                    if (cyc < 32) clr_mask[d][cyc] = 1'b1;
                    prod[d] = '0;
                end
                if (upd_w[d]) begin
                    upd_cnt[d]++;
                    ab = cur_a[8*ma_w[d] +: 8];
                    bb = cur_b[8*mb_w[d] +: 8];
                    prod[d] = prod[d] + (32'(ab) * 32'(bb) << sh_w[d]);
                    shift_seq[d] = (shift_seq[d] << 5) | 64'(sh_w[d]);
                    sel_seq[d]   = (sel_seq[d] << 4) | 64'({ma_w[d], mb_w[d]});
                end
                if (done_w[d]) begin
                    done_cnt[d]++;
                    if (cyc < 32) done_mask[d][cyc] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int          exp_sh [10];
        logic [63:0] exp_seq;
        exp_sh = '{0, 8, 16, 24, 8, 16, 24, 16, 24, 24};
        exp_seq = '0;
        for (int k = 0; k < 10; k++) exp_seq = (exp_seq << 5) | 64'(exp_sh[k]);
        excl_bad  = 0;
        shift_bad = 0;
        quiet_bad = 0;
        clear_logs();

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_outs0", {busy_w[0], done_w[0], upd_w[0], clr_w[0], ma_w[0], mb_w[0], sh_w[0]}, 64'd0);
        chk("reset_outs1", {busy_w[1], done_w[1], upd_w[1], clr_w[1], ma_w[1], mb_w[1], sh_w[1]}, 64'd0);

        // All bytes nonzero: every step issued in order
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        collect(14);
        chk("full_clr",    64'(clr_mask[0]), 64'h2);
        chk("full_shifts", shift_seq[0], exp_seq);
        chk("full_sels",   sel_seq[0], 64'h01_2345_689C);
        chk("full_done",   64'(done_mask[0]), 64'(32'h1 << 12));
        chk("full_busy",   64'(busy_cnt[0]), 64'd12);
        chk("full_prod",   64'(prod[0]), 64'h242D_2080);
        chk("full_prod_ns", 64'(prod[1]), 64'h242D_2080);

        // A = 0: no accumulate, done right after CLR
        start_op(32'h0000_0000, 32'h9ABC_DEF0, 1'b0);
        collect(14);
        chk("zero_clr",  64'(clr_mask[0]), 64'h2);
        chk("zero_upd",  64'(upd_cnt[0]), 64'd0);
        chk("zero_done", 64'(done_mask[0]), 64'(32'h1 << 2));
        chk("zero_prod", 64'(prod[0]), 64'd0);
        chk("zero_done_ns", 64'(done_mask[1]), 64'(32'h1 << 12));
        chk("zero_prod_ns", 64'(prod[1]), 64'd0);

        // 3 * 5: single step vs. all ten steps without skipping
        start_op(32'h0000_0003, 32'h0000_0005, 1'b0);
        collect(14);
        chk("small_upd",   64'(upd_cnt[0]), 64'd1);
        chk("small_sels",  sel_seq[0], 64'h0);
        chk("small_shift", shift_seq[0], 64'h0);
        chk("small_done",  64'(done_mask[0]), 64'(32'h1 << 3));
        chk("small_prod",  64'(prod[0]), 64'd15);
        chk("ns_upd",      64'(upd_cnt[1]), 64'd10);
        chk("ns_shifts",   shift_seq[1], exp_seq);
        chk("ns_done",     64'(done_mask[1]), 64'(32'h1 << 12));
        chk("ns_prod",     64'(prod[1]), 64'd15);

        // Reset during cycle 5 aborts both sequencers
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        collect(5);
        rst = 1'b0;
        quiet_from = 6;
        collect(1);
        rst = 1'b1;
        collect(12);
        chk("abort_done0", 64'(done_cnt[0]), 64'd0);
        chk("abort_done1", 64'(done_cnt[1]), 64'd0);
        chk("abort_quiet", 64'(quiet_bad), 64'd0);
        start_op(32'h0000_0003, 32'h0000_0005, 1'b0);
        collect(4);
        chk("restart_clr",  64'(clr_mask[0]), 64'h2);
        chk("restart_done", 64'(done_mask[0]), 64'(32'h1 << 3));
        collect(10);

        // start held high: back-to-back operations only through IDLE
        start_op(32'h0000_0003, 32'h0000_0005, 1'b1);
        collect(14);
        start = 1'b0;
        chk("hold_clr0",  64'(clr_mask[0]), 64'h2222);
        chk("hold_done0", 64'(done_mask[0]), 64'h0888);
        chk("hold_clr1",  64'(clr_mask[1]), 64'h4002);
        chk("hold_done1", 64'(done_mask[1]), 64'h1000);
        collect(14);

        chk("clr_upd_exclusive", 64'(excl_bad), 64'd0);
        chk("shift_aligned",     64'(shift_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
